// File: rtl/ifu_fetch_if.sv
// Fetch unit bundle: imem request/response, redirect input and decode-side handshake.
// The master modport is the fetch unit side; the slave modport is the memory/decode/commit side.
interface ifu_fetch_if;
  logic        o_imem_req_valid;
  logic        i_imem_req_ready;
  logic [31:0] o_imem_addr;
  logic        i_imem_rsp_valid;
  logic [31:0] i_imem_rsp_data;
  logic        i_imem_rsp_err;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_ins_valid;
  logic        i_ins_ready;
  logic [31:0] o_ins;
  logic [31:0] o_pc;
  logic        o_fault;

  modport master (
    output o_imem_req_valid, o_imem_addr, o_ins_valid, o_ins, o_pc, o_fault,
    input  i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data, i_imem_rsp_err,
           i_redirect, i_redirect_pc, i_ins_ready
  );

  modport slave (
    input  o_imem_req_valid, o_imem_addr, o_ins_valid, o_ins, o_pc, o_fault,
    output i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data, i_imem_rsp_err,
           i_redirect, i_redirect_pc, i_ins_ready
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC register, single-outstanding imem fetch, small instruction buffer.
// Optional access-fault reporting is enabled by defining IFU_FAULT_EN.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  ifu_fetch_if.master    io_bus
);

  localparam int unsigned AW = $clog2(BUF_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        fault;
  } entry_t;

  state_t          r_state, w_state_nxt;
  logic [31:0]     r_fetch_pc, w_fetch_pc_nxt;
  logic [31:0]     r_addr, w_addr_nxt;
  logic [31:0]     r_req_pc, w_req_pc_nxt;
  logic            r_drop, w_drop_nxt;
  logic            r_stall, w_stall_nxt;
  logic [CW-1:0]   r_count, w_count_nxt;
  logic [AW-1:0]   r_rd_ptr, r_wr_ptr;
  entry_t          r_buf [BUF_DEPTH];

  logic            w_push, w_pop, w_credit_ok, w_head_valid;
  logic            w_rsp_fault;
  logic [31:0]     w_redirect_pc;
  entry_t          w_entry;

`ifdef IFU_FAULT_EN
  logic w_unused;
  assign w_rsp_fault    = io_bus.i_imem_rsp_err;
  assign w_unused       = ^io_bus.i_redirect_pc[1:0];
`else
  logic w_unused;
  assign w_rsp_fault    = 1'b0;
  assign w_unused       = ^{io_bus.i_imem_rsp_err, io_bus.i_redirect_pc[1:0]};
`endif

  assign w_redirect_pc = {io_bus.i_redirect_pc[31:2], 2'b00};
  assign w_head_valid  = (r_count != '0);
  assign w_pop         = w_head_valid & io_bus.i_ins_ready;
  assign w_entry.ins   = w_rsp_fault ? NOP : io_bus.i_imem_rsp_data;
  assign w_entry.pc    = r_req_pc;
  assign w_entry.fault = w_rsp_fault;

  // Next-state, fetch PC, drop/stall tracking and buffer occupancy
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_addr_nxt     = r_addr;
    w_req_pc_nxt   = r_req_pc;
    w_drop_nxt     = r_drop;
    w_push         = 1'b0;

    case (r_state)
      S_REQ: begin
        if (io_bus.i_imem_req_ready) begin
          w_state_nxt  = S_WAIT;
          w_req_pc_nxt = r_addr;
          // a held request from before a redirect must not advance the new PC
          if (!r_drop) w_fetch_pc_nxt = r_fetch_pc + 32'd4;
        end
        if (io_bus.i_redirect) w_drop_nxt = 1'b1;
      end
      S_WAIT: begin
        if (io_bus.i_imem_rsp_valid) begin
          w_push     = !r_drop && !io_bus.i_redirect;
          w_drop_nxt = 1'b0;
        end else if (io_bus.i_redirect) begin
          w_drop_nxt = 1'b1;
        end
      end
      default: ;
    endcase

    if (io_bus.i_redirect) w_fetch_pc_nxt = w_redirect_pc;

    w_count_nxt = io_bus.i_redirect ? '0 : CW'(r_count + CW'(w_push) - CW'(w_pop));
    w_stall_nxt = io_bus.i_redirect ? 1'b0 : (r_stall | (w_push & w_rsp_fault));
    w_credit_ok = (w_count_nxt < CW'(BUF_DEPTH)) && !w_stall_nxt;

    case (r_state)
      S_IDLE:  if (w_credit_ok) w_state_nxt = S_REQ;
      S_WAIT:  if (io_bus.i_imem_rsp_valid) w_state_nxt = w_credit_ok ? S_REQ : S_IDLE;
      default: ;
    endcase

    // address is latched only when a new request starts, then held until accepted
    if (r_state != S_REQ && w_state_nxt == S_REQ) w_addr_nxt = w_fetch_pc_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_addr     <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_drop     <= 1'b0;
      r_stall    <= 1'b0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_addr     <= w_addr_nxt;
      r_req_pc   <= w_req_pc_nxt;
      r_drop     <= w_drop_nxt;
      r_stall    <= w_stall_nxt;
      r_count    <= w_count_nxt;
      if (io_bus.i_redirect) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        r_rd_ptr <= r_rd_ptr + AW'(w_pop);
        r_wr_ptr <= r_wr_ptr + AW'(w_push);
      end
    end
  end

  // Buffer storage carries no reset; occupancy alone qualifies it
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_push) r_buf[r_wr_ptr] <= w_entry;
  end

  assign io_bus.o_imem_req_valid = (r_state == S_REQ);
  assign io_bus.o_imem_addr      = r_addr;
  assign io_bus.o_ins_valid      = w_head_valid;
  assign io_bus.o_ins            = w_head_valid ? r_buf[r_rd_ptr].ins : '0;
  assign io_bus.o_pc             = w_head_valid ? r_buf[r_rd_ptr].pc  : '0;
`ifdef IFU_FAULT_EN
  assign io_bus.o_fault          = w_head_valid & r_buf[r_rd_ptr].fault;
`else
  assign io_bus.o_fault          = 1'b0;
`endif

endmodule
